fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a synchronous-read instruction BRAM and
// presents one instruction per cycle to decode, with stall hold and redirect.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_BUBBLE | nothing displayed; BRAM read of fpc in flight
// S_RUN    | displaying inst_doutb (BRAM word for pc_pipe)
// S_HOLD   | decode stalled; displaying the captured hold_inst
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst_addra,
  input  logic [31:0] inst_doutb,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  output logic        fetch_misaligned,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] S_BUBBLE = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;

  logic [1:0]  state;
  logic [31:0] fpc;
  logic [31:0] pc_pipe;
  logic [31:0] hold_inst;
  logic        consume;

  assign inst_addra = fpc;
  assign inst_pc    = pc_pipe;
  assign inst_valid = (state == S_RUN) || (state == S_HOLD);
  assign consume    = inst_valid & ~stall & ~redirect;

  always_comb begin
    inst = NOP_INST;
    case (state)
      S_RUN:   inst = inst_doutb;
      S_HOLD:  inst = hold_inst;
      default: inst = NOP_INST;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state            <= S_BUBBLE;
      fpc              <= RESET_PC;
      pc_pipe          <= RESET_PC;
      hold_inst        <= 32'h0;
      fetch_misaligned <= 1'b0;
      fetch_count      <= 32'h0;
    end else begin
      if (redirect) begin
        // Low bits dropped so the BRAM always sees a word address.
        fpc   <= {redirect_pc[31:2], 2'b00};
        state <= S_BUBBLE;
        if (redirect_pc[1:0] != 2'b00) begin
          fetch_misaligned <= 1'b1;
        end
      end else begin
        case (state)
          S_BUBBLE: begin
            fpc     <= fpc + 32'd4;
            pc_pipe <= fpc;
            state   <= S_RUN;
          end
          S_RUN: begin
            if (stall) begin
              hold_inst <= inst_doutb;
              state     <= S_HOLD;
            end else begin
              fpc     <= fpc + 32'd4;
              pc_pipe <= fpc;
            end
          end
          S_HOLD: begin
            // BRAM keeps reading the held fpc, so on release its output is
            // already the word that follows the held instruction.
            if (!stall) begin
              fpc     <= fpc + 32'd4;
              pc_pipe <= fpc;
              state   <= S_RUN;
            end
          end
          default: state <= S_BUBBLE;
        endcase
      end
      if (consume) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: BRAM model plus a displayed-instruction-stream
// reference model, directed scenarios and randomized stall/redirect traffic.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic        Clock;
  logic        Reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] inst_addra;
  logic [31:0] inst_doutb;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        fetch_misaligned;
  logic [31:0] fetch_count;

  int total = 0;
  int bad   = 0;

  // reference model: what decode should be looking at
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          m_bubble;
  bit          m_mis;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .stall(stall),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .inst_addra(inst_addra),
    .inst_doutb(inst_doutb),
    .inst(inst),
    .inst_pc(inst_pc),
    .inst_valid(inst_valid),
    .fetch_misaligned(fetch_misaligned),
    .fetch_count(fetch_count)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ((a ^ 32'hA5A5_0000) * 32'h9E37_79B1) + 32'h0000_1357;
  endfunction

  always @(posedge Clock) inst_doutb <= mem_word(inst_addra);

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_count  = 32'h0;
    m_bubble = 1'b1;
    m_mis    = 1'b0;
  endtask

  // one clock with the given inputs; model advances on the same edge
  task automatic apply(input bit s, input bit r, input logic [31:0] rp);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    @(posedge Clock);
    if (r) begin
      m_pc     = {rp[31:2], 2'b00};
      m_bubble = 1'b1;
      if (rp[1:0] != 2'b00) m_mis = 1'b1;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (!s) begin
      m_count = m_count + 32'd1;
      m_pc    = m_pc + 32'd4;
    end
    @(negedge Clock);
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
    total++; if (inst !== NOP_INST) begin bad++; $display("FAIL reset_inst got=%h exp=%h", inst, NOP_INST); end
    total++; if (inst_addra !== RESET_PC) begin bad++; $display("FAIL reset_addra got=%h exp=%h", inst_addra, RESET_PC); end
    total++; if (inst_pc !== RESET_PC) begin bad++; $display("FAIL reset_pc got=%h exp=%h", inst_pc, RESET_PC); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", fetch_misaligned); end
  endtask

  task automatic test_stream();
    do_reset();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_bubble got=%b exp=0", inst_valid); end
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b0, 32'h0);
      total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, inst_valid); end
      total++; if (inst_pc !== 32'(i * 4)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, inst_pc, 32'(i * 4)); end
      total++; if (inst !== mem_word(32'(i * 4))) begin bad++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, inst, mem_word(32'(i * 4))); end
    end
    apply(1'b0, 1'b0, 32'h0);
    total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL stream_count got=%0d exp=4", fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 32'h0);
      total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4) begin bad++; $display("FAIL stall_hold_pc[%0d] got=%h/%b exp=4/1", i, inst_pc, inst_valid); end
      total++; if (inst !== mem_word(32'h4)) begin bad++; $display("FAIL stall_hold_inst[%0d] got=%h exp=%h", i, inst, mem_word(32'h4)); end
      total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=1", i, fetch_count); end
    end
    apply(1'b0, 1'b0, 32'h0);
    total++; if (inst_pc !== 32'h8 || inst !== mem_word(32'h8)) begin bad++; $display("FAIL stall_release got=%h/%h exp=8/%h", inst_pc, inst, mem_word(32'h8)); end
    total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL stall_release_count got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) apply(1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 32'h40);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", inst_valid); end
    total++; if (inst !== NOP_INST) begin bad++; $display("FAIL redir_nop got=%h exp=%h", inst, NOP_INST); end
    apply(1'b0, 1'b0, 32'h0);
    total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin bad++; $display("FAIL redir_target got=%h/%b exp=40/1", inst_pc, inst_valid); end
    total++; if (inst !== mem_word(32'h40)) begin bad++; $display("FAIL redir_inst got=%h exp=%h", inst, mem_word(32'h40)); end
    total++; if (fetch_count !== 32'd2) begin bad++; $display("FAIL redir_count got=%0d exp=2", fetch_count); end
  endtask

  task automatic test_redirect_in_hold();
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 32'h0);
    apply(1'b1, 1'b1, 32'h80);
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL hold_redir_bubble got=%b exp=0", inst_valid); end
    apply(1'b0, 1'b0, 32'h0);
    total++; if (inst_pc !== 32'h80 || inst !== mem_word(32'h80)) begin bad++; $display("FAIL hold_redir_target got=%h/%h exp=80/%h", inst_pc, inst, mem_word(32'h80)); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL hold_redir_mis got=%b exp=0", fetch_misaligned); end
    total++; if (fetch_count !== 32'd1) begin bad++; $display("FAIL hold_redir_count got=%0d exp=1", fetch_count); end
  endtask

  task automatic test_misaligned();
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b1, 32'h43);
    total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_set got=%b exp=1", fetch_misaligned); end
    total++; if (inst_addra !== 32'h40) begin bad++; $display("FAIL mis_addra got=%h exp=40", inst_addra); end
    apply(1'b0, 1'b0, 32'h0);
    total++; if (inst_pc !== 32'h40 || inst !== mem_word(32'h40)) begin bad++; $display("FAIL mis_target got=%h/%h exp=40/%h", inst_pc, inst, mem_word(32'h40)); end
    apply(1'b0, 1'b1, 32'h100);
    apply(1'b0, 1'b0, 32'h0);
    total++; if (fetch_misaligned !== 1'b1) begin bad++; $display("FAIL mis_sticky got=%b exp=1", fetch_misaligned); end
    total++; if (inst_pc !== 32'h100) begin bad++; $display("FAIL mis_next_target got=%h exp=100", inst_pc); end
    do_reset();
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL mis_cleared got=%b exp=0", fetch_misaligned); end
  endtask

  task automatic test_async_reset();
    do_reset();
    apply(1'b0, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 32'h0);
    stall = 1'b1;
    #2 Reset = 1'b1;
    #1;
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", inst_valid); end
    total++; if (inst !== NOP_INST) begin bad++; $display("FAIL async_inst got=%h exp=%h", inst, NOP_INST); end
    total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL async_count got=%0d exp=0", fetch_count); end
    total++; if (inst_addra !== RESET_PC) begin bad++; $display("FAIL async_addra got=%h exp=%h", inst_addra, RESET_PC); end
    @(negedge Clock);
    Reset = 1'b0;
    stall = 1'b0;
    model_reset();
    total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL async_release_bubble got=%b exp=0", inst_valid); end
    apply(1'b0, 1'b0, 32'h0);
    total++; if (inst_valid !== 1'b1 || inst_pc !== RESET_PC) begin bad++; $display("FAIL async_restart got=%h/%b exp=%h/1", inst_pc, inst_valid, RESET_PC); end
    total++; if (inst !== mem_word(RESET_PC)) begin bad++; $display("FAIL async_restart_inst got=%h exp=%h", inst, mem_word(RESET_PC)); end
  endtask

  task automatic test_wrap();
    do_reset();
    apply(1'b0, 1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 32'h0);
      total++; if (inst_valid !== 1'b1 || inst_pc !== m_pc) begin bad++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, inst_pc, m_pc); end
      total++; if (inst !== mem_word(m_pc)) begin bad++; $display("FAIL wrap_inst[%0d] got=%h exp=%h", i, inst, mem_word(m_pc)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rp;
    bit s, r;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      s  = ($urandom_range(99) < 30);
      r  = ($urandom_range(99) < 8);
      rp = $urandom_range(255) << 2;
      if ($urandom_range(9) == 0) rp = rp | 32'($urandom_range(3));
      apply(s, r, rp);
      total++;
      if (inst_valid !== !m_bubble) begin bad++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, inst_valid, !m_bubble); end
      if (!m_bubble) begin
        total++; if (inst_pc !== m_pc) begin bad++; $display("FAIL rand_pc[%0d] got=%h exp=%h", i, inst_pc, m_pc); end
        total++; if (inst !== mem_word(m_pc)) begin bad++; $display("FAIL rand_inst[%0d] got=%h exp=%h", i, inst, mem_word(m_pc)); end
      end else begin
        total++; if (inst !== NOP_INST) begin bad++; $display("FAIL rand_nop[%0d] got=%h exp=%h", i, inst, NOP_INST); end
      end
      total++; if (fetch_count !== m_count) begin bad++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, fetch_count, m_count); end
      total++; if (fetch_misaligned !== m_mis) begin bad++; $display("FAIL rand_mis[%0d] got=%b exp=%b", i, fetch_misaligned, m_mis); end
      total++; if (inst_addra[1:0] !== 2'b00) begin bad++; $display("FAIL rand_addra_align[%0d] got=%h", i, inst_addra); end
    end
  endtask

  initial begin
    Clock       = 1'b0;
    Reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_in_hold();
    test_misaligned();
    test_async_reset();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
